prog_loader_mem: RTL
====================

Name: prog_loader_mem

Overview:
- Parametrised program loader and instruction store for the pseudo 8-bit processor.
- Accepts packed {address, instruction} words strobed in by the host, writes them into an internal instruction RAM and tracks which locations are valid.
- Holds the core in reset until the host issues start, then serves registered instruction fetches.
- Successor to the fixed 16-bit/256-entry load path: address and instruction widths are generic, and it adds load accounting, an error flag and a CPU-reset handoff.

Parameters:
- AW, 8: address width; RAM depth = 2**AW.
- IW, 8: instruction width.
- NOP_WORD, 0: value returned when fetching an unwritten address, or when not in RUN.

Ports:
- clk1  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  AW+IW  load word; in[AW+IW-1:IW] = address, in[IW-1:0] = instruction.
- done  input  1  load strobe; a word is accepted on each 0->1 transition sampled at clk1.
- start  input  1  level; requests handoff to the core.
- fetch_addr  input  AW  core fetch address.
- fetch_data  output  IW  registered fetch result.
- cpu_rst  output  1  reset to the core; high in every state except RUN.
- load_ack  output  1  one-cycle pulse the cycle after a word is written.
- word_cnt  output  AW+1  accepted writes since reset; saturates at 2**(AW+1)-1.
- hi_addr  output  AW  highest address written since reset.
- state  output  2  00 IDLE, 01 LOAD, 10 RUN.
- err  output  1  sticky error flag.
- checksum  output  IW  running checksum (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high) clears: state=IDLE, cpu_rst=1, fetch_data=NOP_WORD, load_ack=0, word_cnt=0, hi_addr=0, err=0, checksum=0, the valid bitmap (all entries 0), and the done edge register (cleared to 0).
- RAM contents are not cleared by reset; the cleared bitmap masks them.
- Edge detect: done_q registered each cycle; accept = done & ~done_q.
  - A done held high for N cycles is accepted once.
  - done already high on the first cycle after reset counts as an edge.
- Write on accept, in IDLE or LOAD:
  - mem[addr] <= instr, valid[addr] <= 1.
  - word_cnt increments (duplicate addresses overwrite and still count).
  - hi_addr <= max(hi_addr, addr).
  - load_ack = 1 next cycle.
- State machine:
  - IDLE -> LOAD on first accept.
  - LOAD -> RUN when start=1.
  - IDLE + start: stay in IDLE, set err (nothing loaded).
  - RUN persists until rst; no other exit.
- accept and start in the same LOAD cycle: the word is written first, then the block enters RUN; the word is fetchable.
- accept while in RUN: no write, no count, no ack; err set.
- cpu_rst is registered: deasserts the same edge state becomes RUN, i.e. 1 cycle after start is sampled.
- Fetch:
  - fetch_data <= (state==RUN && valid[fetch_addr]) ? mem[fetch_addr] : NOP_WORD.
  - 1-cycle latency; a new address every cycle is allowed.
- Address wrap: none needed; the full 2**AW space is addressable.
- word_cnt saturates rather than wrapping.
- rst during LOAD or RUN: immediate return to IDLE, cpu_rst=1; prior RAM data is inaccessible until rewritten.

Optional Feature:
- Macro LOAD_CHECKSUM_EN.
- Defined: checksum <= checksum ^ instr ^ addr[IW-1:0] (addr zero-extended if AW<IW) on every accepted write; the value is frozen once in RUN.
- Undefined: checksum is tied to 0 and no checksum logic is generated.

Test Plan:
- Reset, then load in=16'h0003, 16'h0110, 16'h0201 (AW=IW=8), start -> word_cnt=3, hi_addr=2, state=10, cpu_rst falls 1 cycle after start.
- In RUN, fetch_addr=1 -> fetch_data=8'h10 next cycle; fetch_addr=5 -> NOP_WORD (0x00).
- done held high for 3 cycles with in=16'h0420 -> exactly one write, word_cnt +1, a single load_ack pulse.
- start with no prior load -> state stays 00, err=1; done edge with 16'h0203 in same cycle as start in LOAD -> fetch addr 2 returns 0x03.
- After RUN, strobe done with 16'h0055 -> err=1, fetch addr 0 still returns the original 0x03; then rst -> state=00, all bitmap entries clear, fetch returns NOP_WORD.
- With LOAD_CHECKSUM_EN, load 16'h0003 and 16'h0110 -> checksum = 0x03^0x00^0x10^0x01 = 0x12; without the macro -> checksum=0.

Source files
------------

// File: rtl/prog_loader_mem_if.sv
// Host/core bus of the program loader: load words, handoff control, fetch port and status.
// The master modport is the host/core side; the slave modport is the loader itself.
interface prog_loader_mem_if #(
  parameter int AW = 8,
  parameter int IW = 8
);
  logic [AW+IW-1:0] in;
  logic             done;
  logic             start;
  logic [AW-1:0]    fetch_addr;
  logic [IW-1:0]    fetch_data;
  logic             cpu_rst;
  logic             load_ack;
  logic [AW:0]      word_cnt;
  logic [AW-1:0]    hi_addr;
  logic [1:0]       state;
  logic             err;
  logic [IW-1:0]    checksum;

  modport master (
    output in, done, start, fetch_addr,
    input  fetch_data, cpu_rst, load_ack, word_cnt, hi_addr, state, err, checksum
  );

  modport slave (
    input  in, done, start, fetch_addr,
    output fetch_data, cpu_rst, load_ack, word_cnt, hi_addr, state, err, checksum
  );
endinterface

// File: rtl/prog_loader_mem.sv
// Program loader and instruction store: edge-strobed {addr,instr} writes, valid bitmap,
// core reset handoff and registered fetch. Optional running checksum under LOAD_CHECKSUM_EN.
module prog_loader_mem #(
  parameter int            AW       = 8,
  parameter int            IW       = 8,
  parameter logic [IW-1:0] NOP_WORD = '0
) (
  input  logic              clk1,
  input  logic              rst,
  prog_loader_mem_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10
  } state_t;

  localparam int DEPTH = 2 ** AW;

  state_t            state_q, state_d;
  logic              done_q;
  logic              accept;
  logic              wr_en;
  logic              err_set;
  logic              err_q;
  logic              cpu_rst_q;
  logic              load_ack_q;
  logic [AW:0]       word_cnt_q;
  logic [AW-1:0]     hi_addr_q;
  logic [IW-1:0]     fetch_data_q;
  logic [DEPTH-1:0]  valid_q;
  logic [IW-1:0]     mem [DEPTH];
  logic [AW-1:0]     ld_addr;
  logic [IW-1:0]     ld_instr;

  function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
    return (v == {(AW+1){1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [AW-1:0] max_addr(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign ld_addr  = bus.in[AW+IW-1:IW];
  assign ld_instr = bus.in[IW-1:0];
  assign accept   = bus.done & ~done_q;

  // Next state, write enable and error detection
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        wr_en = accept;
        if (accept) begin
          state_d = ST_LOAD;
        end else if (bus.start) begin
          err_set = 1'b1;
        end
      end
      ST_LOAD: begin
        // A word strobed alongside start is still written before handoff.
        wr_en = accept;
        if (bus.start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        err_set = accept;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and status registers
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      cpu_rst_q  <= 1'b1;
      load_ack_q <= 1'b0;
      word_cnt_q <= '0;
      hi_addr_q  <= '0;
      err_q      <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= bus.done;
      cpu_rst_q  <= (state_d != ST_RUN);
      load_ack_q <= wr_en;
      err_q      <= err_q | err_set;
      if (wr_en) begin
        word_cnt_q       <= sat_inc(word_cnt_q);
        hi_addr_q        <= max_addr(hi_addr_q, ld_addr);
        valid_q[ld_addr] <= 1'b1;
      end
    end
  end

  // Instruction RAM: contents survive reset, the valid bitmap hides stale words
  always_ff @(posedge clk1) begin
    if (wr_en) begin
      mem[ld_addr] <= ld_instr;
    end
  end

  // Registered fetch, one cycle latency
  always_ff @(posedge clk1) begin
    if (rst) begin
      fetch_data_q <= NOP_WORD;
    end else if (state_q == ST_RUN && valid_q[bus.fetch_addr]) begin
      fetch_data_q <= mem[bus.fetch_addr];
    end else begin
      fetch_data_q <= NOP_WORD;
    end
  end

`ifdef LOAD_CHECKSUM_EN
  localparam int XW = (AW > IW) ? AW : IW;

  logic [IW-1:0] checksum_q;

  function automatic logic [IW-1:0] fold_addr(input logic [AW-1:0] a);
    logic [XW-1:0] ext;
    ext = XW'(a);
    return ext[IW-1:0];
  endfunction

  // Writes stop once in RUN, so the checksum freezes there naturally
  always_ff @(posedge clk1) begin
    if (rst) begin
      checksum_q <= '0;
    end else if (wr_en) begin
      checksum_q <= checksum_q ^ ld_instr ^ fold_addr(ld_addr);
    end
  end

  assign bus.checksum = checksum_q;
`else
  assign bus.checksum = '0;
`endif

  assign bus.fetch_data = fetch_data_q;
  assign bus.cpu_rst    = cpu_rst_q;
  assign bus.load_ack   = load_ack_q;
  assign bus.word_cnt   = word_cnt_q;
  assign bus.hi_addr    = hi_addr_q;
  assign bus.state      = state_q;
  assign bus.err        = err_q;

endmodule
